mine_neighbour_counter: RTL and testbench

Downstream stage of the mine-placement block. After the board is filled, it scans the latched mine map one cell per clock and writes each cell's adjacent-mine count (0..8) into a count map. The display and reveal logic read that map. Completion is signalled with a one-cycle `done` pulse.

---
 rtl/mine_neighbour_counter_pkg.sv | 15 +
 rtl/mine_neighbour_counter_if.sv | 25 ++
 rtl/mine_neighbour_counter_nbr_sum.sv | 33 +++
 rtl/mine_neighbour_counter.sv | 128 ++++++++++++
 tb/tb_mine_neighbour_counter.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/mine_neighbour_counter_pkg.sv
// Shared definitions for the mine-board blocks: board geometry, the mine marker
// value and the neighbour-counter state encoding.
package saper_pkg;

    localparam int         BOARD_MAX = 8;
    localparam int         CNT_W     = 4;
    localparam logic [3:0] MINE_MARK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } nbr_state_t;

endpackage

// File: rtl/mine_neighbour_counter_if.sv
// Start/map/count bundle between the mine-placement side and the neighbour
// counter; master drives the request, slave returns counts and status.
interface mine_neighbour_counter_if #(
    parameter int BOARD_MAX = saper_pkg::BOARD_MAX,
    parameter int CNT_W     = saper_pkg::CNT_W
);

    logic                               start;
    logic [BOARD_MAX*BOARD_MAX-1:0]     mine_map;
    logic [4:0]                         dimension_size;
    logic [BOARD_MAX*BOARD_MAX*CNT_W-1:0] count_map;
    logic                               busy;
    logic                               done;

    modport master (
        output start, mine_map, dimension_size,
        input  count_map, busy, done
    );

    modport slave (
        input  start, mine_map, dimension_size,
        output count_map, busy, done
    );

endinterface

// File: rtl/mine_neighbour_counter_nbr_sum.sv
// Combinational count of mines in the 8 cells around the cursor, restricted to
// the active n x n area; the cursor cell itself is never counted.
module nbr_sum #(
    parameter int BOARD_MAX = saper_pkg::BOARD_MAX
) (
    input  logic [BOARD_MAX*BOARD_MAX-1:0]     map_i,
    input  logic [$clog2(BOARD_MAX+1)-1:0]     n_i,
    input  logic [$clog2(BOARD_MAX)-1:0]       x_i,
    input  logic [$clog2(BOARD_MAX)-1:0]       y_i,
    output logic [3:0]                         sum_o
);

    always_comb begin
        sum_o = '0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                int nx;
                int ny;
                nx = int'(x_i) + dx;
                ny = int'(y_i) + dy;
                // Bits beyond the active area are ignored even when set.
                if (!(dx == 0 && dy == 0) &&
                    nx >= 0 && nx < int'(n_i) &&
                    ny >= 0 && ny < int'(n_i)) begin
                    if (map_i[ny*BOARD_MAX + nx]) begin
                        sum_o = sum_o + 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/mine_neighbour_counter.sv
// Raster-scans the latched mine map one cell per clock and writes each cell's
// neighbour count. Define MINE_NEIGHBOUR_MARK_EN to write MINE_MARK on mine cells.
//
//   state | meaning
//   IDLE  | waiting for start; latches map/n and clears the count map on start
//   SCAN  | writes one count field per cycle at cursor (x,y)
//   DONE  | one-cycle done pulse, count map valid
module mine_neighbour_counter #(
    parameter int BOARD_MAX = saper_pkg::BOARD_MAX,
    parameter int CNT_W     = saper_pkg::CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    mine_neighbour_counter_if.slave   bus_if
);

    import saper_pkg::*;

    localparam int CELLS = BOARD_MAX * BOARD_MAX;
    localparam int N_W   = $clog2(BOARD_MAX + 1);
    localparam int X_W   = $clog2(BOARD_MAX);

    nbr_state_t               state_q, state_d;
    logic [CELLS-1:0]         map_q, map_d;
    logic [N_W-1:0]           n_q, n_d;
    logic [X_W-1:0]           x_q, x_d;
    logic [X_W-1:0]           y_q, y_d;
    logic [CELLS*CNT_W-1:0]   count_map_q, count_map_d;

    logic [N_W-1:0]           n_clamped;
    logic [3:0]               sum;
    logic [CNT_W-1:0]         cell_val;
    logic                     last_x;
    logic                     last_y;
    int                       cell_idx;

    nbr_sum #(
        .BOARD_MAX (BOARD_MAX)
    ) u_nbr_sum (
        .map_i (map_q),
        .n_i   (n_q),
        .x_i   (x_q),
        .y_i   (y_q),
        .sum_o (sum)
    );

    always_comb begin
        if (int'(bus_if.dimension_size) > BOARD_MAX) begin
            n_clamped = N_W'(BOARD_MAX);
        end else begin
            n_clamped = N_W'(bus_if.dimension_size);
        end
    end

    assign last_x   = (N_W'(x_q) == n_q - N_W'(1));
    assign last_y   = (N_W'(y_q) == n_q - N_W'(1));
    assign cell_idx = int'(y_q) * BOARD_MAX + int'(x_q);

`ifdef MINE_NEIGHBOUR_MARK_EN
    assign cell_val = map_q[cell_idx] ? CNT_W'(MINE_MARK) : CNT_W'(sum);
`else
    assign cell_val = CNT_W'(sum);
`endif

    always_comb begin
        state_d     = state_q;
        map_d       = map_q;
        n_d         = n_q;
        x_d         = x_q;
        y_d         = y_q;
        count_map_d = count_map_q;

        case (state_q)
            IDLE: begin
                if (bus_if.start) begin
                    map_d       = bus_if.mine_map;
                    n_d         = n_clamped;
                    x_d         = '0;
                    y_d         = '0;
                    count_map_d = '0;
                    state_d     = (n_clamped == '0) ? DONE : SCAN;
                end
            end
            SCAN: begin
                count_map_d[cell_idx*CNT_W +: CNT_W] = cell_val;
                if (last_x) begin
                    x_d = '0;
                    if (last_y) begin
                        state_d = DONE;
                    end else begin
                        y_d = y_q + X_W'(1);
                    end
                end else begin
                    x_d = x_q + X_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            map_q       <= '0;
            n_q         <= '0;
            x_q         <= '0;
            y_q         <= '0;
            count_map_q <= '0;
        end else begin
            state_q     <= state_d;
            map_q       <= map_d;
            n_q         <= n_d;
            x_q         <= x_d;
            y_q         <= y_d;
            count_map_q <= count_map_d;
        end
    end

    assign bus_if.count_map = count_map_q;
    assign bus_if.busy      = (state_q == SCAN);
    assign bus_if.done      = (state_q == DONE);

endmodule

// File: tb/tb_mine_neighbour_counter.sv
// Randomised and directed scans of mine_neighbour_counter compared against a
// scatter-style neighbour model (each mine increments its active neighbours).
module tb_mine_neighbour_counter;

    localparam int BM    = 8;
    localparam int CW    = 4;
    localparam int CELLS = BM * BM;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mine_neighbour_counter_if #(.BOARD_MAX(BM), .CNT_W(CW)) bus ();

    mine_neighbour_counter #(
        .BOARD_MAX (BM),
        .CNT_W     (CW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int exp_cnt [CELLS];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic build_model(input logic [63:0] map, input int dim);
        int n;
        n = (dim > BM) ? BM : dim;
        for (int i = 0; i < CELLS; i++) exp_cnt[i] = 0;
        for (int y = 0; y < n; y++) begin
            for (int x = 0; x < n; x++) begin
                if (map[y*BM + x]) begin
                    for (int yy = y - 1; yy <= y + 1; yy++) begin
                        for (int xx = x - 1; xx <= x + 1; xx++) begin
                            if ((xx != x || yy != y) && xx >= 0 && xx < n && yy >= 0 && yy < n)
                                exp_cnt[yy*BM + xx]++;
                        end
                    end
                end
            end
        end
`ifdef MINE_NEIGHBOUR_MARK_EN
        for (int y = 0; y < n; y++)
            for (int x = 0; x < n; x++)
                if (map[y*BM + x]) exp_cnt[y*BM + x] = 15;
`endif
    endtask

    task automatic check_map(input string tag);
        for (int i = 0; i < CELLS; i++)
            check_val($sformatf("%s.cell[%0d]", tag, i), 64'(bus.count_map[i*CW +: CW]), 64'(exp_cnt[i]));
    endtask

    // Start a scan at the next edge, then check busy/done every cycle and the
    // count map in the done cycle; hold keeps start high for back-to-back scans.
    task automatic do_scan(input string tag, input logic [63:0] map, input int dim,
                           input bit hold, input logic [63:0] map_next);
        int n;
        int nn;
        n  = (dim > BM) ? BM : dim;
        nn = n * n;
        build_model(map, dim);
        @(negedge clk);
        bus.start          = 1'b1;
        bus.mine_map       = map;
        bus.dimension_size = 5'(dim);
        @(posedge clk);
        #1;
        for (int s = 1; s <= nn + 2; s++) begin
            if (s > 1) begin
                @(posedge clk);
                #1;
            end
            check_val($sformatf("%s.busy@%0d", tag, s), 64'(bus.busy), 64'(s <= nn));
            check_val($sformatf("%s.done@%0d", tag, s), 64'(bus.done), 64'(s == nn + 1));
            if (s == nn + 1) check_map(tag);
            if (hold) begin
                bus.start = 1'b1;
                if (s == 3) bus.mine_map = map_next;
            end else if (s <= nn) begin
                bus.start          = 1'($urandom_range(0, 1));
                bus.mine_map       = {$urandom, $urandom};
                bus.dimension_size = 5'($urandom_range(0, 31));
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] map_a;
        logic [63:0] map_b;

        rst                = 1'b1;
        bus.start          = 1'b0;
        bus.mine_map       = '0;
        bus.dimension_size = '0;
        repeat (3) @(posedge clk);
        #1;
        build_model('0, 0);
        check_val("reset.busy", 64'(bus.busy), 64'd0);
        check_val("reset.done", 64'(bus.done), 64'd0);
        check_map("reset");
        rst = 1'b0;

        // Single mine in a 5x5 board.
        do_scan("single", 64'd1 << (2*BM + 2), 5, 1'b0, '0);
        // Fully mined 8x8: corners 3, edges 5, interior 8.
        do_scan("full", '1, 8, 1'b0, '0);
        // Mines only outside a 3x3 active area.
        do_scan("outside", (64'd1 << (4*BM + 4)) | (64'd1 << 3), 3, 1'b0, '0);
        // n=0 completes immediately; n=20 clamps to 8.
        do_scan("n0", {$urandom, $urandom}, 0, 1'b0, '0);
        do_scan("n20", {$urandom, $urandom}, 20, 1'b0, '0);

        // Reset in the middle of an 8x8 scan.
        @(negedge clk);
        bus.start          = 1'b1;
        bus.mine_map       = '1;
        bus.dimension_size = 5'd8;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        build_model('0, 0);
        check_val("midrst.busy", 64'(bus.busy), 64'd0);
        check_val("midrst.done", 64'(bus.done), 64'd0);
        check_map("midrst");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("midrst.idle_done@%0d", i), 64'(bus.done), 64'd0);
            check_val($sformatf("midrst.idle_busy@%0d", i), 64'(bus.busy), 64'd0);
        end
        do_scan("after_rst", {$urandom, $urandom}, 8, 1'b0, '0);

        // Start held high: back-to-back n=4 scans, map changed mid-scan.
        map_a = {$urandom, $urandom};
        map_b = ~map_a;
        do_scan("hold0", map_a, 4, 1'b1, map_b);
        do_scan("hold1", map_b, 4, 1'b1, map_b);
        bus.start = 1'b0;

        for (int r = 0; r < 25; r++) begin
            logic [63:0] m;
            m = {$urandom, $urandom};
            if (r % 3 == 0) m = m & {$urandom, $urandom};
            do_scan($sformatf("rand%0d", r), m, $urandom_range(0, 12), 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
